clock_divider_step: RTL and testbench

// - Generates the slow counter clock `clk_div` from the 50 MHz board clock `clk`.
// - Two modes:
//   - free-running: 50% duty, fixed period.
//   - single-step: one pulse per debounced press of a push-button.
// - Feeds the counter chain: contador_3bits / contador_2bits take clk_div.
// - Also emits a one-cycle `tick` for logic synchronous to clk.

---
 rtl/clock_divider_step_pkg.sv | 15 +
 rtl/clock_divider_step_if.sv | 30 +++
 rtl/debouncer.sv | 58 +++++
 rtl/clock_divider_step.sv | 122 ++++++++++++
 tb/tb_clock_divider_step.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/clock_divider_step_pkg.sv
// Shared constants for the board clock divider and its button debouncer.
package clock_divider_step_pkg;

    // Mode encoding used by the divider FSM.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'd0;
    localparam mode_t MODE_RUN  = 2'd1;
    localparam mode_t MODE_STEP = 2'd2;

    // Defaults for the 50 MHz board: 1 Hz divided clock, 10 ms debounce window.
    localparam int unsigned DEF_DIV_HALF   = 25_000_000;
    localparam int unsigned DEF_DEB_CYCLES = 500_000;

endpackage

// File: rtl/clock_divider_step_if.sv
// Control inputs and clock outputs of the divider, grouped as one bundle.
interface clock_divider_step_if;

    logic enable;
    logic step_mode;
    logic step_btn;
    logic clk_div;
    logic tick;
    logic running;

    // master drives the controls; slave is the divider itself.
    modport master (
        output enable,
        output step_mode,
        output step_btn,
        input  clk_div,
        input  tick,
        input  running
    );

    modport slave (
        input  enable,
        input  step_mode,
        input  step_btn,
        output clk_div,
        output tick,
        output running
    );

endinterface

// File: rtl/debouncer.sv
// Push-button debouncer: 2-flop synchroniser followed by a stability counter.
// btn_rise pulses for one cycle in the same cycle btn_level first reads 1.
module debouncer
    import clock_divider_step_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [DEB_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive samples that differ
    // from the current level; any sample matching the level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                rise_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + DEB_W'(1);
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;

endmodule

// File: rtl/clock_divider_step.sv
// Slow counter clock generator: free-running 50% divider or debounced single step.
// The datapath acts on the mode decoded this cycle; the registered mode is used
// only to spot a RUN<->STEP switch, which restarts the divider from low.
module clock_divider_step
    import clock_divider_step_pkg::*;
#(
    parameter int unsigned DIV_HALF   = DEF_DIV_HALF,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_divider_step_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DIV_HALF);

    mode_t            state_q;
    mode_t            state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_div_q;
    logic             clk_div_d;
    logic             tick_q;
    logic             tick_d;
    logic             running_q;
    logic             running_d;
    logic             mode_switch;
    logic             btn_level;
    logic             btn_rise;

    debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (bus.step_btn),
        .btn_level(btn_level),
        .btn_rise (btn_rise)
    );

    // Mode state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MODE_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode decode from the live controls.
    always_comb begin
        state_d = MODE_HOLD;
        if (!bus.enable) begin
            state_d = MODE_HOLD;
        end else if (!bus.step_mode) begin
            state_d = MODE_RUN;
        end else begin
            state_d = MODE_STEP;
        end
    end

    // Divider / step datapath next state.
    always_comb begin
        cnt_d       = cnt_q;
        clk_div_d   = clk_div_q;
        tick_d      = 1'b0;
        running_d   = bus.enable & ~bus.step_mode;
        mode_switch = ((state_q == MODE_RUN) && (state_d == MODE_STEP)) ||
                      ((state_q == MODE_STEP) && (state_d == MODE_RUN));
        if (mode_switch) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end else begin
            case (state_d)
                MODE_RUN: begin
                    if (cnt_q == CNT_W'(DIV_HALF - 1)) begin
                        cnt_d     = '0;
                        clk_div_d = ~clk_div_q;
                        tick_d    = ~clk_div_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MODE_STEP: begin
                    // Only a fresh debounced press raises clk_div, so a button
                    // held across a mode switch must be released first.
                    cnt_d = '0;
                    if (btn_rise) begin
                        clk_div_d = 1'b1;
                        tick_d    = 1'b1;
                    end else if (!btn_level) begin
                        clk_div_d = 1'b0;
                    end
                end
                default: begin
                    cnt_d     = cnt_q;
                    clk_div_d = clk_div_q;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign bus.clk_div = clk_div_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_clock_divider_step.sv
// Directed bench for clock_divider_step with DIV_HALF=4, DEB_CYCLES=3.
module tb_clock_divider_step;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   ticks;
    logic [5:0] bounce;

    clock_divider_step_if bus ();

    clock_divider_step #(
        .DIV_HALF  (4),
        .DEB_CYCLES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n edges expecting a steady clk_div and no tick.
    task automatic expect_run(input int n, input string tag, input logic cd);
        for (int i = 0; i < n; i++) begin
            cyc();
            check(tag, {31'd0, bus.clk_div}, {31'd0, cd});
            check({tag, "_tick"}, {31'd0, bus.tick}, 32'd0);
        end
    endtask

    task automatic expect_rise(input string tag);
        cyc();
        check(tag, {31'd0, bus.clk_div}, 32'd1);
        check({tag, "_tick"}, {31'd0, bus.tick}, 32'd1);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_btn  = 1'b0;
        cyc();
        cyc();
        check("rst_clk_div", {31'd0, bus.clk_div}, 32'd0);
        check("rst_tick", {31'd0, bus.tick}, 32'd0);
        check("rst_running", {31'd0, bus.running}, 32'd0);

        // 1: free-running, rise on 4th edge, period 8
        reset      = 1'b0;
        bus.enable = 1'b1;
        expect_run(3, "s1_low", 1'b0);
        check("s1_running", {31'd0, bus.running}, 32'd1);
        expect_rise("s1_rise");
        expect_run(3, "s1_high", 1'b1);
        expect_run(1, "s1_fall", 1'b0);
        expect_run(3, "s1_low2", 1'b0);
        expect_rise("s1_rise2");

        // 2: freeze at cnt=2 for 5 cycles, toggle 2 edges after re-enable
        expect_run(2, "s2_pre", 1'b1);
        bus.enable = 1'b0;
        expect_run(5, "s2_frozen", 1'b1);
        check("s2_running", {31'd0, bus.running}, 32'd0);
        bus.enable = 1'b1;
        expect_run(1, "s2_resume", 1'b1);
        expect_run(1, "s2_toggle", 1'b0);

        // 3: step mode, glitch rejected, clean press and release
        bus.step_mode = 1'b1;
        expect_run(1, "s3_switch", 1'b0);
        check("s3_running", {31'd0, bus.running}, 32'd0);
        bus.step_btn = 1'b1;
        expect_run(2, "s3_glitch", 1'b0);
        bus.step_btn = 1'b0;
        expect_run(8, "s3_glitch_quiet", 1'b0);
        bus.step_btn = 1'b1;
        expect_run(5, "s3_press_wait", 1'b0);
        expect_rise("s3_rise");
        expect_run(2, "s3_held", 1'b1);
        bus.step_btn = 1'b0;
        expect_run(5, "s3_release_wait", 1'b1);
        expect_run(1, "s3_fall", 1'b0);

        // 4: bouncy press gives exactly one tick
        bounce = 6'b101101;
        ticks  = 0;
        for (int i = 5; i >= 0; i--) begin
            bus.step_btn = bounce[i];
            cyc();
            ticks += int'(bus.tick);
        end
        bus.step_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            ticks += int'(bus.tick);
        end
        check("s4_ticks", ticks, 32'd1);
        check("s4_level", {31'd0, bus.clk_div}, 32'd1);
        bus.step_btn = 1'b0;
        expect_run(5, "s4_release_wait", 1'b1);
        expect_run(1, "s4_fall", 1'b0);

        // 5: mode switches restart the divider from low
        bus.step_mode = 1'b0;
        expect_run(1, "s5_to_run", 1'b0);
        expect_run(3, "s5_low", 1'b0);
        expect_rise("s5_rise");
        expect_run(1, "s5_high", 1'b1);
        bus.step_mode = 1'b1;
        expect_run(1, "s5_to_step", 1'b0);
        check("s5_running", {31'd0, bus.running}, 32'd0);
        expect_run(3, "s5_step_idle", 1'b0);
        bus.step_mode = 1'b0;
        expect_run(1, "s5_back_run", 1'b0);
        expect_run(3, "s5_low2", 1'b0);
        expect_rise("s5_rerise");

        // button held across RUN->STEP: no tick until released and re-pressed
        bus.step_btn = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        bus.step_mode = 1'b1;
        expect_run(1, "s5_held_switch", 1'b0);
        expect_run(6, "s5_held_no_tick", 1'b0);
        bus.step_btn = 1'b0;
        expect_run(8, "s5_released", 1'b0);
        bus.step_btn = 1'b1;
        expect_run(5, "s5_repress_wait", 1'b0);
        expect_rise("s5_repress");
        bus.step_btn  = 1'b0;
        bus.step_mode = 1'b0;
        expect_run(1, "s5_final_switch", 1'b0);
        expect_run(3, "s5_final_low", 1'b0);
        expect_rise("s5_final_rise");
        expect_run(1, "s5_mid_high", 1'b1);

        // 6: reset mid-period, then resume as after power-up
        reset = 1'b1;
        cyc();
        check("s6_rst_clk_div", {31'd0, bus.clk_div}, 32'd0);
        check("s6_rst_tick", {31'd0, bus.tick}, 32'd0);
        check("s6_rst_running", {31'd0, bus.running}, 32'd0);
        cyc();
        reset = 1'b0;
        expect_run(3, "s6_low", 1'b0);
        expect_rise("s6_rise");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
